game_ctrl: RTL and testbench



---
 rtl/game_pkg.sv | 16 +
 rtl/tick_timer.sv | 34 +++
 rtl/game_ctrl.sv | 110 +++++++++++
 tb/tb_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: state encoding and lives sizing.
package game_pkg;

  localparam int unsigned LIVES_W   = 3;
  localparam int unsigned LIVES_MAX = 7;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReady = 3'd1,
    StPlay  = 3'd2,
    StDying = 3'd3,
    StWin   = 3'd4,
    StLose  = 3'd5
  } state_e;

endpackage

// File: rtl/tick_timer.sv
// Counts game-frame ticks and flags the tick that lands on the programmed terminal count.
module tick_timer #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            tick_i,
  input  logic [CntW-1:0] limit_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign done_o = tick_i && (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow FSM: lives, ready/death delays, respawn pulses and end-of-game flags.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned READY_TICKS = 120,
  parameter int unsigned DIE_TICKS   = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               crash,
  input  logic               all_eaten,
  output logic [2:0]         state,
  output logic               run_en,
  output logic               respawn,
  output logic [LIVES_W-1:0] lives,
  output logic               over,
  output logic               win
);

  localparam int unsigned MaxTicks = (READY_TICKS > DIE_TICKS) ? READY_TICKS : DIE_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  state_e             state_d, state_q;
  logic [LIVES_W-1:0] lives_d, lives_q;
  logic               run_en_d, run_en_q;
  logic               respawn_d, respawn_q;
  logic               over_d, over_q;
  logic               win_d, win_q;

  logic            timer_tick;
  logic            timer_done;
  logic [CntW-1:0] timer_limit;

  // Only the two timed states consume ticks; the limit follows the current state.
  assign timer_tick  = tick && (state_q == StReady || state_q == StDying);
  assign timer_limit = (state_q == StDying) ? CntW'(DIE_TICKS - 1) : CntW'(READY_TICKS - 1);

  tick_timer #(
    .CntW (CntW)
  ) u_tick_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_d != state_q),
    .tick_i  (timer_tick),
    .limit_i (timer_limit),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    unique case (state_q)
      StIdle, StWin, StLose: begin
        if (start) begin
          state_d = StReady;
          lives_d = LIVES_W'(LIVES);
        end
      end
      StReady: begin
        if (timer_done) state_d = StPlay;
      end
      StPlay: begin
        if (all_eaten) begin
          state_d = StWin;
        end else if (crash) begin
          state_d = StDying;
          lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
        end
      end
      StDying: begin
        if (timer_done) state_d = (lives_q == '0) ? StLose : StReady;
      end
      default: state_d = StIdle;
    endcase

    run_en_d  = (state_d == StPlay);
    respawn_d = (state_d == StReady) && (state_q != StReady);
    over_d    = (state_d == StWin) || (state_d == StLose);
    win_d     = (state_d == StWin);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lives_q   <= '0;
      run_en_q  <= 1'b0;
      respawn_q <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      run_en_q  <= run_en_d;
      respawn_q <= respawn_d;
      over_q    <= over_d;
      win_q     <= win_d;
    end
  end

  assign state   = state_q;
  assign lives   = lives_q;
  assign run_en  = run_en_q;
  assign respawn = respawn_q;
  assign over    = over_q;
  assign win     = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with LIVES=2, READY_TICKS=3, DIE_TICKS=2, one tick per 4 clks.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       crash = 1'b0;
  logic       all_eaten = 1'b0;
  logic [2:0] state;
  logic       run_en;
  logic       respawn;
  logic [2:0] lives;
  logic       over;
  logic       win;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .LIVES       (2),
    .READY_TICKS (3),
    .DIE_TICKS   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .crash     (crash),
    .all_eaten (all_eaten),
    .state     (state),
    .run_en    (run_en),
    .respawn   (respawn),
    .lives     (lives),
    .over      (over),
    .win       (win)
  );

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse followed by three idle clocks; counts respawn cycles seen.
  task automatic do_tick(output int rc);
    rc = 0;
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    if (respawn) rc++;
    repeat (3) begin
      clk1();
      if (respawn) rc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) clk1();
    total++;
    if ({state, run_en, respawn, lives, over, win} !== 10'b0) begin
      bad++;
      $display("FAIL reset_vals got=%b want=%b", {state, run_en, respawn, lives, over, win}, 10'b0);
    end
    rst = 1'b1;
    repeat (2) clk1();
    total++;
    if (state !== 3'd0 || respawn !== 1'b0) begin
      bad++;
      $display("FAIL reset_release state=%0d respawn=%b want 0/0", state, respawn);
    end
  endtask

  task automatic test_start();
    int rc;
    start = 1'b1;
    clk1();
    start = 1'b0;
    total++;
    if (state !== 3'd1 || lives !== 3'd2 || respawn !== 1'b1 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL start_enter state=%0d lives=%0d resp=%b run=%b want 1/2/1/0",
               state, lives, respawn, run_en);
    end
    clk1();
    total++;
    if (respawn !== 1'b0) begin
      bad++;
      $display("FAIL start_resp_width respawn=%b want 0", respawn);
    end
    do_tick(rc);
    do_tick(rc);
    total++;
    if (state !== 3'd1 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL ready_hold state=%0d run=%b want 1/0", state, run_en);
    end
    do_tick(rc);
    total++;
    if (state !== 3'd2 || run_en !== 1'b1) begin
      bad++;
      $display("FAIL ready_exit state=%0d run=%b want 2/1", state, run_en);
    end
  endtask

  task automatic test_crash();
    int rc;
    int rc_sum;
    crash = 1'b1;
    clk1();
    crash = 1'b0;
    total++;
    if (state !== 3'd3 || lives !== 3'd1 || run_en !== 1'b0 || respawn !== 1'b0) begin
      bad++;
      $display("FAIL crash_enter state=%0d lives=%0d run=%b resp=%b want 3/1/0/0",
               state, lives, run_en, respawn);
    end
    do_tick(rc);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL dying_hold state=%0d want 3", state);
    end
    do_tick(rc);
    total++;
    if (state !== 3'd1 || rc !== 1) begin
      bad++;
      $display("FAIL dying_exit state=%0d respawn_clks=%0d want 1/1", state, rc);
    end
    rc_sum = 0;
    do_tick(rc);
    rc_sum += rc;
    do_tick(rc);
    rc_sum += rc;
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL ready2_hold state=%0d want 1", state);
    end
    do_tick(rc);
    rc_sum += rc;
    total++;
    if (state !== 3'd2 || run_en !== 1'b1 || rc_sum !== 0) begin
      bad++;
      $display("FAIL ready2_exit state=%0d run=%b respawn_clks=%0d want 2/1/0",
               state, run_en, rc_sum);
    end
  endtask

  task automatic test_lose();
    int rc;
    int rc_sum;
    crash = 1'b1;
    clk1();
    crash = 1'b0;
    total++;
    if (state !== 3'd3 || lives !== 3'd0) begin
      bad++;
      $display("FAIL last_crash state=%0d lives=%0d want 3/0", state, lives);
    end
    do_tick(rc);
    rc_sum = rc;
    do_tick(rc);
    rc_sum += rc;
    total++;
    if (state !== 3'd5 || over !== 1'b1 || win !== 1'b0 || run_en !== 1'b0 || rc_sum !== 0) begin
      bad++;
      $display("FAIL lose_enter state=%0d over=%b win=%b run=%b respawn_clks=%0d want 5/1/0/0/0",
               state, over, win, run_en, rc_sum);
    end
    crash = 1'b1;
    all_eaten = 1'b1;
    do_tick(rc);
    crash = 1'b0;
    all_eaten = 1'b0;
    total++;
    if ({state, run_en, respawn, lives, over, win} !== {3'd5, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}
        || rc !== 0) begin
      bad++;
      $display("FAIL lose_stable got=%b want=%b", {state, run_en, respawn, lives, over, win},
               {3'd5, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_restart(input logic [2:0] from_state);
    int rc;
    start = 1'b1;
    clk1();
    start = 1'b0;
    total++;
    if (state !== 3'd1 || lives !== 3'd2 || over !== 1'b0 || win !== 1'b0 || respawn !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_%0d state=%0d lives=%0d over=%b win=%b resp=%b want 1/2/0/0/1",
               from_state, state, lives, over, win, respawn);
    end
    clk1();
    total++;
    if (respawn !== 1'b0) begin
      bad++;
      $display("FAIL restart_resp_width respawn=%b want 0", respawn);
    end
    repeat (3) do_tick(rc);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL restart_to_play state=%0d want 2", state);
    end
  endtask

  task automatic test_win();
    crash = 1'b1;
    all_eaten = 1'b1;
    clk1();
    crash = 1'b0;
    all_eaten = 1'b0;
    total++;
    if (state !== 3'd4 || over !== 1'b1 || win !== 1'b1 || lives !== 3'd2 || run_en !== 1'b0) begin
      bad++;
      $display("FAIL win_priority state=%0d over=%b win=%b lives=%0d run=%b want 4/1/1/2/0",
               state, over, win, lives, run_en);
    end
  endtask

  task automatic test_play_ignores_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
    total++;
    if (state !== 3'd2 || respawn !== 1'b0 || lives !== 3'd2) begin
      bad++;
      $display("FAIL play_start state=%0d resp=%b lives=%0d want 2/0/2", state, respawn, lives);
    end
  endtask

  task automatic test_tick_with_crash();
    int rc;
    tick = 1'b1;
    crash = 1'b1;
    clk1();
    tick = 1'b0;
    crash = 1'b0;
    total++;
    if (state !== 3'd3 || lives !== 3'd1) begin
      bad++;
      $display("FAIL tick_crash_enter state=%0d lives=%0d want 3/1", state, lives);
    end
    repeat (3) clk1();
    do_tick(rc);
    total++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL tick_crash_clear state=%0d want 3", state);
    end
    do_tick(rc);
    total++;
    if (state !== 3'd1 || rc !== 1) begin
      bad++;
      $display("FAIL tick_crash_exit state=%0d respawn_clks=%0d want 1/1", state, rc);
    end
  endtask

  task automatic test_async_reset();
    int rc;
    do_tick(rc);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({state, run_en, respawn, lives, over, win} !== 10'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", {state, run_en, respawn, lives, over, win},
               10'b0);
    end
    clk1();
    rst = 1'b1;
    rc = 0;
    repeat (4) begin
      clk1();
      if (respawn) rc++;
    end
    total++;
    if (state !== 3'd0 || rc !== 0 || lives !== 3'd0) begin
      bad++;
      $display("FAIL post_reset state=%0d respawn_clks=%0d lives=%0d want 0/0/0", state, rc, lives);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_crash();
    test_lose();
    test_restart(3'd5);
    test_win();
    test_restart(3'd4);
    test_play_ignores_start();
    test_tick_with_crash();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
